div_result_stage: RTL

Result back-end that sits directly downstream of the SRT divider datapath and its controller. At operation start it captures the original operands; when the divider finishes it takes the raw quotient/remainder and applies the architectural special-case fixups (divide-by-zero, signed overflow). It then queues the result in a 2-entry output FIFO with a valid/ready handshake. Its `start_ready` output backpressures the divider controller so that no result is ever lost.

---
 rtl/div_result_stage_if.sv | 37 +++
 rtl/div_result_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/div_result_stage_if.sv
// div_result_stage_if: operand capture, raw divider result and output FIFO
// handshake bundle for div_result_stage. Revision 1.0.
`default_nettype none

interface div_result_stage_if #(
   parameter int parallelism = 32,
   parameter int TAG_W       = 4
);
   logic                   start;
   logic                   start_ready;
   logic                   usigned;
   logic [parallelism-1:0] dividend;
   logic [parallelism-1:0] divisor;
   logic [TAG_W-1:0]       tag;
   logic                   div_done;
   logic [parallelism-1:0] quotient;
   logic [parallelism-1:0] reminder;
   logic                   out_valid;
   logic                   out_ready;
   logic [parallelism-1:0] out_quotient;
   logic [parallelism-1:0] out_reminder;
   logic [TAG_W-1:0]       out_tag;
   logic                   out_dz;
   logic                   out_ovf;

   modport master (
      output start, usigned, dividend, divisor, tag, div_done, quotient, reminder, out_ready,
      input  start_ready, out_valid, out_quotient, out_reminder, out_tag, out_dz, out_ovf
   );

   modport slave (
      input  start, usigned, dividend, divisor, tag, div_done, quotient, reminder, out_ready,
      output start_ready, out_valid, out_quotient, out_reminder, out_tag, out_dz, out_ovf
   );
endinterface

`default_nettype wire

// File: rtl/div_result_stage.sv
// +--------------------------------------------------------------------------+
// | div_result_stage: divider result back-end with dz/ovf fixups and a       |
// | 2-entry output FIFO. DIVRES_SPECIAL_EN enables fixups and flags.         |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module div_result_stage #(
   parameter int parallelism = 32,
   parameter int TAG_W       = 4
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   div_result_stage_if.slave   bus
);
   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_DIV = 2'd1,
      S_HOLD     = 2'd2
   } state_t;

   state_t                 r_state;
   logic                   r_start_ready;
   logic [TAG_W-1:0]       r_tag;
   logic [parallelism-1:0] r_hold_q;
   logic [parallelism-1:0] r_hold_r;
   logic [parallelism-1:0] r_mem_q   [2];
   logic [parallelism-1:0] r_mem_r   [2];
   logic [TAG_W-1:0]       r_mem_tag [2];
   logic                   r_wr_ptr;
   logic                   r_rd_ptr;
   logic [1:0]             r_count;

   logic                   w_pop;
   logic                   w_push_ok;
   logic                   w_push;
   logic [parallelism-1:0] w_res_q;
   logic [parallelism-1:0] w_res_r;
   logic [parallelism-1:0] w_in_q;
   logic [parallelism-1:0] w_in_r;

`ifdef DIVRES_SPECIAL_EN
   logic [parallelism-1:0] r_dividend;
   logic                   r_dz;
   logic                   r_ovf;
   logic                   r_mem_dz  [2];
   logic                   r_mem_ovf [2];
   logic                   w_start_dz;
   logic                   w_start_ovf;

   assign w_start_dz  = (bus.divisor == '0);
   assign w_start_ovf = ~bus.usigned
                      & (bus.dividend == {1'b1, {(parallelism-1){1'b0}}})
                      & (bus.divisor == '1);
   // dz wins over ovf; the two cannot coincide anyway since divisors differ
   assign w_res_q = r_dz ? '1 : (r_ovf ? r_dividend : bus.quotient);
   assign w_res_r = r_dz ? r_dividend : (r_ovf ? '0 : bus.reminder);
   assign bus.out_dz  = r_mem_dz[r_rd_ptr];
   assign bus.out_ovf = r_mem_ovf[r_rd_ptr];
`else
   logic w_unused_ops;

   assign w_unused_ops = ^{bus.usigned, bus.dividend, bus.divisor};
   assign w_res_q      = bus.quotient;
   assign w_res_r      = bus.reminder;
   assign bus.out_dz   = 1'b0;
   assign bus.out_ovf  = 1'b0;
`endif

   assign w_pop     = bus.out_valid & bus.out_ready;
   assign w_push_ok = (r_count != 2'd2) | w_pop;
   assign w_push    = ((r_state == S_WAIT_DIV) & bus.div_done & w_push_ok)
                    | ((r_state == S_HOLD) & w_push_ok);
   assign w_in_q    = (r_state == S_HOLD) ? r_hold_q : w_res_q;
   assign w_in_r    = (r_state == S_HOLD) ? r_hold_r : w_res_r;

   assign bus.start_ready  = r_start_ready;
   assign bus.out_valid    = (r_count != 2'd0);
   assign bus.out_quotient = r_mem_q[r_rd_ptr];
   assign bus.out_reminder = r_mem_r[r_rd_ptr];
   assign bus.out_tag      = r_mem_tag[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_start_ready <= 1'b1;
         r_tag         <= '0;
         r_hold_q      <= '0;
         r_hold_r      <= '0;
         r_wr_ptr      <= 1'b0;
         r_rd_ptr      <= 1'b0;
         r_count       <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            r_mem_q[i]   <= '0;
            r_mem_r[i]   <= '0;
            r_mem_tag[i] <= '0;
`ifdef DIVRES_SPECIAL_EN
            r_mem_dz[i]  <= 1'b0;
            r_mem_ovf[i] <= 1'b0;
`endif
         end
`ifdef DIVRES_SPECIAL_EN
         r_dividend <= '0;
         r_dz       <= 1'b0;
         r_ovf      <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_tag         <= bus.tag;
`ifdef DIVRES_SPECIAL_EN
                  r_dividend    <= bus.dividend;
                  r_dz          <= w_start_dz;
                  r_ovf         <= w_start_ovf;
`endif
                  r_state       <= S_WAIT_DIV;
                  r_start_ready <= 1'b0;
               end
            end
            S_WAIT_DIV: begin
               if (bus.div_done) begin
                  if (w_push_ok) begin
                     r_state       <= S_IDLE;
                     r_start_ready <= 1'b1;
                  end else begin
                     // tag and flags stay in r_tag/r_dz/r_ovf while holding
                     r_hold_q <= w_res_q;
                     r_hold_r <= w_res_r;
                     r_state  <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (w_push_ok) begin
                  r_state       <= S_IDLE;
                  r_start_ready <= 1'b1;
               end
            end
            default: begin
               r_state       <= S_IDLE;
               r_start_ready <= 1'b1;
            end
         endcase

         if (w_push) begin
            r_mem_q[r_wr_ptr]   <= w_in_q;
            r_mem_r[r_wr_ptr]   <= w_in_r;
            r_mem_tag[r_wr_ptr] <= r_tag;
`ifdef DIVRES_SPECIAL_EN
            r_mem_dz[r_wr_ptr]  <= r_dz;
            r_mem_ovf[r_wr_ptr] <= r_ovf;
`endif
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

`default_nettype wire
